// File: rtl/pulse_train_gen.sv
// Pulse train generator: after a start strobe, waits NUM_DLY cycles and then emits NUM_PULSES
// pulses of HIGH_CYC high / LOW_CYC low. Define PULSE_TRAIN_GEN_RETRIG_EN to let start_i restart a running train.
module pulse_train_gen #(
  parameter int NUM_DLY    = 13,
  parameter int HIGH_CYC   = 1,
  parameter int LOW_CYC    = 1,
  parameter int NUM_PULSES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic pulse_o,
  output logic busy_o,
  output logic done_o
);

  localparam int MAX_DH  = (NUM_DLY > HIGH_CYC) ? NUM_DLY : HIGH_CYC;
  localparam int MAX_CYC = (MAX_DH > LOW_CYC) ? MAX_DH : LOW_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int PW      = $clog2(NUM_PULSES + 1);

  localparam logic [CW-1:0] DLY_LOAD   = CW'(NUM_DLY - 1);
  localparam logic [CW-1:0] HIGH_LOAD  = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] LOW_LOAD   = CW'(LOW_CYC - 1);
  localparam logic [CW-1:0] CNT_ZERO   = '0;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(NUM_PULSES - 1);
  localparam logic [PW-1:0] PCNT_ZERO  = '0;
  localparam logic [PW-1:0] PCNT_ONE   = PW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    HIGH,
    LOW
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;
  logic          done_nxt;
  logic          restart;

`ifdef PULSE_TRAIN_GEN_RETRIG_EN
  assign restart = start_i;
`else
  assign restart = start_i && (state == IDLE);
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pcnt_nxt  = pcnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = IDLE;
      end
      DELAY: begin
        if (cnt == CNT_ZERO) begin
          state_nxt = HIGH;
          cnt_nxt   = HIGH_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      HIGH: begin
        if (cnt != CNT_ZERO) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (pcnt == PCNT_ZERO) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = LOW;
          cnt_nxt   = LOW_LOAD;
          pcnt_nxt  = pcnt - PCNT_ONE;
        end
      end
      LOW: begin
        if (cnt == CNT_ZERO) begin
          state_nxt = HIGH;
          cnt_nxt   = HIGH_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
    endcase
    // A restart overrides whatever the running train would have done, including its done strobe.
    if (restart) begin
      state_nxt = DELAY;
      cnt_nxt   = DLY_LOAD;
      pcnt_nxt  = PULSE_LOAD;
      done_nxt  = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= CNT_ZERO;
      pcnt    <= PCNT_ZERO;
      pulse_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pcnt    <= pcnt_nxt;
      pulse_o <= (state_nxt == HIGH);
      busy_o  <= (state_nxt != IDLE);
      done_o  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: three differently configured instances are driven with
// directed and random starts/resets; expected waveforms come from closed-form pulse-train arithmetic.
module tb_pulse_train_gen;

  localparam int NI = 3;
  localparam int P_D  [NI] = '{13, 13, 1};
  localparam int P_H  [NI] = '{1, 2, 1};
  localparam int P_L  [NI] = '{1, 3, 1};
  localparam int P_NP [NI] = '{1, 3, 2};

  typedef struct packed {
    logic [31:0] edge_idx;
    logic [8:0]  pbd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] start;
  logic [NI-1:0] pulse;
  logic [NI-1:0] busy;
  logic [NI-1:0] done;

  exp_t sb_q[$];
  bit   active [NI];
  int   k      [NI];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pulse_train_gen #(.NUM_DLY(13), .HIGH_CYC(1), .LOW_CYC(1), .NUM_PULSES(1)) u_dflt (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]),
    .pulse_o(pulse[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  pulse_train_gen #(.NUM_DLY(13), .HIGH_CYC(2), .LOW_CYC(3), .NUM_PULSES(3)) u_train (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]),
    .pulse_o(pulse[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  pulse_train_gen #(.NUM_DLY(1), .HIGH_CYC(1), .LOW_CYC(1), .NUM_PULSES(2)) u_min (
    .clk(clk), .rst_n(rst_n), .start_i(start[2]),
    .pulse_o(pulse[2]), .busy_o(busy[2]), .done_o(done[2])
  );

  function automatic int total_busy(int i);
    return P_D[i] + P_NP[i] * P_H[i] + (P_NP[i] - 1) * P_L[i];
  endfunction

  // Expected {pulse, busy, done} in the cycle following edge e, measured from acceptance edge k.
  function automatic logic [2:0] model_out(int i, int e);
    int d, r, per;
    logic p;
    if (!active[i]) return 3'b000;
    d   = e - k[i];
    per = P_H[i] + P_L[i];
    p   = 1'b0;
    if (d >= P_D[i]) begin
      r = d - P_D[i];
      if ((r / per) < P_NP[i] && (r % per) < P_H[i]) p = 1'b1;
    end
    return {p, d < total_busy(i), d == total_busy(i)};
  endfunction

  function automatic bit accepts(int i);
`ifdef PULSE_TRAIN_GEN_RETRIG_EN
    return 1'b1;
`else
    return !active[i] || ((edge_cnt - 1 - k[i]) >= total_busy(i));
`endif
  endfunction

  task automatic check_async();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({pulse[i], busy[i], done[i]} !== 3'b000) begin
        failures++;
        $display("[TB] FAIL async_rst_u%0d: got p/b/d=%b required 000", i, {pulse[i], busy[i], done[i]});
      end
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic [NI-1:0] st);
    exp_t ex;
    @(negedge clk);
    start = st;
    if (rst_n && !rst) begin
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) active[i] = 1'b0;
      #1 check_async();
    end
    rst_n = rst;
    edge_cnt++;
    for (int i = 0; i < NI; i++) begin
      if (!rst) active[i] = 1'b0;
      else if (st[i] && accepts(i)) begin
        active[i] = 1'b1;
        k[i]      = edge_cnt;
      end
    end
    ex.edge_idx = 32'(edge_cnt);
    ex.pbd      = '0;
    for (int i = 0; i < NI; i++) ex.pbd[3*i +: 3] = model_out(i, edge_cnt);
    sb_q.push_back(ex);
  endtask

  task automatic check_output(input exp_t ex);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({pulse[i], busy[i], done[i]} !== ex.pbd[3*i +: 3]) begin
        failures++;
        $display("[TB] FAIL out_u%0d edge %0d: got p/b/d=%b required %b",
                 i, ex.edge_idx, {pulse[i], busy[i], done[i]}, ex.pbd[3*i +: 3]);
      end
    end
  endtask

  initial begin : monitor
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        ex = sb_q.pop_front();
        check_output(ex);
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0;
    start = '0;
    for (int i = 0; i < NI; i++) begin
      active[i] = 1'b0;
      k[i]      = 0;
    end
    for (int c = 0; c < 6; c++) apply_stimulus(1'b0, 3'($urandom));
    repeat (2) apply_stimulus(1'b1, 3'b000);

    apply_stimulus(1'b1, 3'b111);
    repeat (40) apply_stimulus(1'b1, 3'b000);

    apply_stimulus(1'b1, 3'b111);
    repeat (4) apply_stimulus(1'b1, 3'b000);
    apply_stimulus(1'b1, 3'b111);
    repeat (40) apply_stimulus(1'b1, 3'b000);

    repeat (60) apply_stimulus(1'b1, 3'b111);
    repeat (40) apply_stimulus(1'b1, 3'b000);

    // Reset lands in the middle of the long delay of the first two instances.
    apply_stimulus(1'b1, 3'b111);
    repeat (4) apply_stimulus(1'b1, 3'b000);
    apply_stimulus(1'b0, 3'b000);
    for (int c = 0; c < 3; c++) apply_stimulus(1'b0, 3'($urandom));
    repeat (20) apply_stimulus(1'b1, 3'b000);

    for (int c = 0; c < 3000; c++) begin
      logic [NI-1:0] st;
      for (int i = 0; i < NI; i++) st[i] = ($urandom_range(0, 5) == 0);
      apply_stimulus($urandom_range(0, 499) != 0, st);
    end
    apply_stimulus(1'b1, 3'b000);
    repeat (40) apply_stimulus(1'b1, 3'b000);

    for (int c = 0; c < 5 && sb_q.size() > 0; c++) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending entries required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Generates a deterministic train of rectangular pulses on a single output line after a programmable start delay, triggered by a one-cycle start strobe. It is the transmit-side counterpart of the team's edge detector. It produces the edges that the detector consumes and serves as a stimulus source and timing generator in the same clock domain. A busy/done handshake lets a controller sequence back-to-back trains.

## Interface
- NUM_DLY, default 13: cycles from start acceptance to first pulse rising; legal range ≥1.
- HIGH_CYC, default 1: cycles each pulse stays high; ≥1.
- LOW_CYC, default 1: low cycles between consecutive pulses; ≥1.
- NUM_PULSES, default 1: pulses per train; ≥1.

Ports:
- clk  input  1  rising-edge clock, single domain.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start_i  input  1  start strobe, sampled on rising clk.
- pulse_o  output  1  generated pulse line, registered.
- busy_o  output  1  train in progress, registered.
- done_o  output  1  one-cycle completion strobe, registered.

## Operation
- States: IDLE, DELAY, HIGH, LOW.
- IDLE: start_i=1 at an edge causes the following transitions:
  - state DELAY, down-counter loaded with NUM_DLY-1.
  - pulse counter loaded with NUM_PULSES-1.
- DELAY: decrement each edge. At counter 0, go to HIGH and load HIGH_CYC-1.
- HIGH: decrement each edge. At 0, the transition depends on the pulse counter:
  - pulse counter 0 → IDLE, assert done_o.
  - otherwise → LOW, load LOW_CYC-1, decrement pulse counter.
- LOW: decrement each edge. At 0, go to HIGH and load HIGH_CYC-1.
- Outputs:
  - pulse_o=1 exactly while state is HIGH.
  - busy_o=1 while state is not IDLE.
  - done_o=1 for the single cycle after the HIGH→IDLE transition.
- Counter widths:
  - cycle counter is $clog2(max(NUM_DLY,HIGH_CYC,LOW_CYC)+1) bits.
  - pulse counter is $clog2(NUM_PULSES+1) bits.
  - No wrap occurs in legal configurations.
- start_i while busy: ignored unless the macro below is defined.
- start_i in the done_o cycle: state is IDLE, so it is accepted, giving back-to-back trains.

## Timing
- Reset values: pulse_o=0, busy_o=0, done_o=0, state IDLE, counters 0. Outputs clear asynchronously on rst_n fall.
- Reset mid-train: the train is aborted immediately, with no done_o. After rst_n rises, the block waits for a new start_i.
- Start accepted at edge k:
  - busy_o=1 from edge k.
  - First pulse_o rise at edge k+NUM_DLY.
  - Pulse n (0-based) rises at edge k+NUM_DLY+n·(HIGH_CYC+LOW_CYC) and lasts HIGH_CYC cycles.
- Total busy_o duration is NUM_DLY + NUM_PULSES·HIGH_CYC + (NUM_PULSES-1)·LOW_CYC cycles.
- At the edge ending the last pulse, busy_o falls and done_o rises for one cycle.
- No combinational input-to-output paths exist.

## Configuration
- PULSE_TRAIN_GEN_RETRIG_EN defined:
  - start_i=1 in any non-IDLE state restarts the train. State goes to DELAY and both counters reload as in IDLE.
  - busy_o stays 1 and done_o is not asserted for the aborted train.
  - If the restart hits the done_o edge, IDLE acceptance applies.
- Not defined: start_i is ignored while busy_o=1.

## Test plan
- Reset: hold rst_n=0, toggle start_i → pulse_o, busy_o, done_o stay 0.
  - Assert rst_n=0 mid-DELAY → all outputs 0 asynchronously, no done_o.
- Defaults (13,1,1,1), start at edge k:
  - pulse_o high exactly for the cycle starting at edge k+13.
  - busy_o high edges k..k+13.
  - done_o at edge k+14.
  - An edge detector with NUM_DLY=13 fed from pulse_o flags exactly one rising edge.
- Train (13,2,3,3), start at edge k:
  - pulse_o high at edges k+13..14, k+18..19 and k+23..24.
  - busy_o falls and done_o pulses at edge k+25.
- Back-to-back: start_i held high through the done_o cycle → second train starts at that edge, and busy_o drops for exactly one cycle.
- Start while busy at edge k+5:
  - Without macro: ignored, timing unchanged.
  - With PULSE_TRAIN_GEN_RETRIG_EN: first pulse moves to edge k+18, and only one done_o occurs.
